// File: rtl/axil_reg_slave.sv
`timescale 1ns/1ps
// axil_reg_slave
//   AXI4-Lite responder exposing N_CTRL control registers (PS writes, PL
//   reads) followed by N_STAT status registers (PL drives, PS reads).
//   Independent write and read FSMs; byte-strobe writes; SLVERR for writes
//   to status/unmapped words and for reads of unmapped words.
//
// Ports
//   axi_clock, axi_aresetn        clock, asynchronous active-low reset
//   S_AXI_aw*/w*/b*               write address, data and response channels
//   S_AXI_ar*/r*                  read address and data channels
//   ctrl_regs     [32*N_CTRL]     control register contents, reg i at [32i+:32]
//   ctrl_wr_pulse [N_CTRL]        one-cycle strobe per committed write
//   stat_regs     [32*N_STAT]     status inputs, sampled on the AR handshake
//   stat_rd_pulse [N_STAT]        one-cycle strobe per status read
module axil_reg_slave #(
    parameter int N_CTRL = 8,
    parameter int N_STAT = 8
) (
    input  logic                  axi_clock,
    input  logic                  axi_aresetn,
    input  logic [31:0]           S_AXI_awaddr,
    input  logic [2:0]            S_AXI_awprot,
    input  logic                  S_AXI_awvalid,
    output logic                  S_AXI_awready,
    input  logic [31:0]           S_AXI_wdata,
    input  logic [3:0]            S_AXI_wstrb,
    input  logic                  S_AXI_wvalid,
    output logic                  S_AXI_wready,
    output logic [1:0]            S_AXI_bresp,
    output logic                  S_AXI_bvalid,
    input  logic                  S_AXI_bready,
    input  logic [31:0]           S_AXI_araddr,
    input  logic [2:0]            S_AXI_arprot,
    input  logic                  S_AXI_arvalid,
    output logic                  S_AXI_arready,
    output logic [31:0]           S_AXI_rdata,
    output logic [1:0]            S_AXI_rresp,
    output logic                  S_AXI_rvalid,
    input  logic                  S_AXI_rready,
    output logic [32*N_CTRL-1:0]  ctrl_regs,
    output logic [N_CTRL-1:0]     ctrl_wr_pulse,
    input  logic [32*N_STAT-1:0]  stat_regs,
    output logic [N_STAT-1:0]     stat_rd_pulse
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_RESP}           r_state_t;

    w_state_t                  w_state_q, w_state_d;
    logic                      aw_held_q, aw_held_d;
    logic                      w_held_q, w_held_d;
    logic [9:0]                aw_idx_q, aw_idx_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [3:0]                wstrb_q, wstrb_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [N_CTRL-1:0][31:0]   ctrl_q, ctrl_d;
    logic [N_CTRL-1:0]         ctrl_wr_pulse_q, ctrl_wr_pulse_d;

    r_state_t                  r_state_q, r_state_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic [31:0]               rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [N_STAT-1:0]         stat_rd_pulse_q, stat_rd_pulse_d;

    // Only address bits [11:2] are decoded; prot is ignored.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_awaddr[31:12], S_AXI_awaddr[1:0], S_AXI_awprot,
                         S_AXI_araddr[31:12], S_AXI_araddr[1:0], S_AXI_arprot};

    // Write path: collect AW and W independently, commit, then respond.
    always_comb begin
        w_state_d       = w_state_q;
        aw_held_d       = aw_held_q;
        w_held_d        = w_held_q;
        aw_idx_d        = aw_idx_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        bvalid_d        = bvalid_q;
        bresp_d         = bresp_q;
        ctrl_d          = ctrl_q;
        ctrl_wr_pulse_d = '0;

        case (w_state_q)
            W_IDLE: begin
                if (S_AXI_awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = S_AXI_awaddr[11:2];
                end
                if (S_AXI_wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = S_AXI_wdata;
                    wstrb_d  = S_AXI_wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    w_state_d = W_COMMIT;
                end
            end
            W_COMMIT: begin
                // Anything that does not match a control word is an error.
                bresp_d = RESP_SLVERR;
                for (int i = 0; i < N_CTRL; i++) begin
                    if (aw_idx_q == 10'(i)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb_q[b]) begin
                                ctrl_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                            end
                        end
                        // Strobe fires even for an all-zero wstrb.
                        ctrl_wr_pulse_d[i] = 1'b1;
                        bresp_d            = RESP_OKAY;
                    end
                end
                bvalid_d  = 1'b1;
                w_state_d = W_RESP;
            end
            W_RESP: begin
                if (S_AXI_bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        // Readies are registered from the next state so they rise one edge
        // after reset release and on the edge that completes the B handshake.
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    // Read path: decode and capture on the AR handshake, hold until rready.
    always_comb begin
        r_state_d       = r_state_q;
        rvalid_d        = rvalid_q;
        rdata_d         = rdata_q;
        rresp_d         = rresp_q;
        stat_rd_pulse_d = '0;

        case (r_state_q)
            R_IDLE: begin
                if (S_AXI_arvalid && arready_q) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                    // ctrl_q is the pre-write value if a commit shares this edge.
                    for (int i = 0; i < N_CTRL; i++) begin
                        if (S_AXI_araddr[11:2] == 10'(i)) begin
                            rdata_d = ctrl_q[i];
                            rresp_d = RESP_OKAY;
                        end
                    end
                    for (int j = 0; j < N_STAT; j++) begin
                        if (S_AXI_araddr[11:2] == 10'(N_CTRL + j)) begin
                            rdata_d            = stat_regs[32*j +: 32];
                            rresp_d            = RESP_OKAY;
                            stat_rd_pulse_d[j] = 1'b1;
                        end
                    end
                    rvalid_d  = 1'b1;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (S_AXI_rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge axi_clock or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_state_q       <= W_IDLE;
            aw_held_q       <= 1'b0;
            w_held_q        <= 1'b0;
            aw_idx_q        <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            awready_q       <= 1'b0;
            wready_q        <= 1'b0;
            bvalid_q        <= 1'b0;
            bresp_q         <= RESP_OKAY;
            ctrl_q          <= '0;
            ctrl_wr_pulse_q <= '0;
            r_state_q       <= R_IDLE;
            arready_q       <= 1'b0;
            rvalid_q        <= 1'b0;
            rdata_q         <= '0;
            rresp_q         <= RESP_OKAY;
            stat_rd_pulse_q <= '0;
        end else begin
            w_state_q       <= w_state_d;
            aw_held_q       <= aw_held_d;
            w_held_q        <= w_held_d;
            aw_idx_q        <= aw_idx_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            awready_q       <= awready_d;
            wready_q        <= wready_d;
            bvalid_q        <= bvalid_d;
            bresp_q         <= bresp_d;
            ctrl_q          <= ctrl_d;
            ctrl_wr_pulse_q <= ctrl_wr_pulse_d;
            r_state_q       <= r_state_d;
            arready_q       <= arready_d;
            rvalid_q        <= rvalid_d;
            rdata_q         <= rdata_d;
            rresp_q         <= rresp_d;
            stat_rd_pulse_q <= stat_rd_pulse_d;
        end
    end

    assign S_AXI_awready = awready_q;
    assign S_AXI_wready  = wready_q;
    assign S_AXI_bvalid  = bvalid_q;
    assign S_AXI_bresp   = bresp_q;
    assign S_AXI_arready = arready_q;
    assign S_AXI_rvalid  = rvalid_q;
    assign S_AXI_rdata   = rdata_q;
    assign S_AXI_rresp   = rresp_q;
    assign ctrl_regs     = ctrl_q;
    assign ctrl_wr_pulse = ctrl_wr_pulse_q;
    assign stat_rd_pulse = stat_rd_pulse_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
`timescale 1ns/1ps
// Bench for axil_reg_slave (N_CTRL = N_STAT = 8). Expected responses are
// queued when a transaction is issued and popped when the DUT answers.
module tb_axil_reg_slave;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  S_AXI_awaddr = '0;
    logic [2:0]   S_AXI_awprot = '0;
    logic         S_AXI_awvalid = 1'b0;
    logic         S_AXI_awready;
    logic [31:0]  S_AXI_wdata = '0;
    logic [3:0]   S_AXI_wstrb = '0;
    logic         S_AXI_wvalid = 1'b0;
    logic         S_AXI_wready;
    logic [1:0]   S_AXI_bresp;
    logic         S_AXI_bvalid;
    logic         S_AXI_bready = 1'b0;
    logic [31:0]  S_AXI_araddr = '0;
    logic [2:0]   S_AXI_arprot = '0;
    logic         S_AXI_arvalid = 1'b0;
    logic         S_AXI_arready;
    logic [31:0]  S_AXI_rdata;
    logic [1:0]   S_AXI_rresp;
    logic         S_AXI_rvalid;
    logic         S_AXI_rready = 1'b0;
    logic [255:0] ctrl_regs;
    logic [7:0]   ctrl_wr_pulse;
    logic [255:0] stat_regs = '0;
    logic [7:0]   stat_rd_pulse;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic [1:0] exp_b_q[$];
    rexp_t      exp_r_q[$];

    int vectors = 0;
    int miscompares = 0;

    axil_reg_slave #(.N_CTRL(8), .N_STAT(8)) dut (
        .axi_clock     (clk),
        .axi_aresetn   (rst_n),
        .S_AXI_awaddr  (S_AXI_awaddr),
        .S_AXI_awprot  (S_AXI_awprot),
        .S_AXI_awvalid (S_AXI_awvalid),
        .S_AXI_awready (S_AXI_awready),
        .S_AXI_wdata   (S_AXI_wdata),
        .S_AXI_wstrb   (S_AXI_wstrb),
        .S_AXI_wvalid  (S_AXI_wvalid),
        .S_AXI_wready  (S_AXI_wready),
        .S_AXI_bresp   (S_AXI_bresp),
        .S_AXI_bvalid  (S_AXI_bvalid),
        .S_AXI_bready  (S_AXI_bready),
        .S_AXI_araddr  (S_AXI_araddr),
        .S_AXI_arprot  (S_AXI_arprot),
        .S_AXI_arvalid (S_AXI_arvalid),
        .S_AXI_arready (S_AXI_arready),
        .S_AXI_rdata   (S_AXI_rdata),
        .S_AXI_rresp   (S_AXI_rresp),
        .S_AXI_rvalid  (S_AXI_rvalid),
        .S_AXI_rready  (S_AXI_rready),
        .ctrl_regs     (ctrl_regs),
        .ctrl_wr_pulse (ctrl_wr_pulse),
        .stat_regs     (stat_regs),
        .stat_rd_pulse (stat_rd_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drivers only; every task is entered and left 1ns after a rising edge.
    // w_lead > 0: W leads AW by w_lead cycles; w_lead < 0: AW leads W.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, input bit stall_b,
                             output logic [1:0] resp, output int lat,
                             output logic [7:0] pulse_at_b, output logic [7:0] pulse_after,
                             output bit timeout);
        int aw_start, w_start, cyc;
        bit aw_done, w_done, hs_aw, hs_w;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        cyc = 0; aw_done = 0; w_done = 0; timeout = 0; lat = 0;
        resp = 2'bxx; pulse_at_b = 'x; pulse_after = '0;
        S_AXI_bready = 1'b0;
        while (!(aw_done && w_done) && cyc < 40) begin
            if (cyc == aw_start) begin S_AXI_awvalid = 1'b1; S_AXI_awaddr = addr; end
            if (cyc == w_start) begin
                S_AXI_wvalid = 1'b1; S_AXI_wdata = data; S_AXI_wstrb = strb;
            end
            hs_aw = S_AXI_awvalid && S_AXI_awready;
            hs_w  = S_AXI_wvalid && S_AXI_wready;
            @(posedge clk); #1;
            if (hs_aw) begin S_AXI_awvalid = 1'b0; aw_done = 1; end
            if (hs_w)  begin S_AXI_wvalid = 1'b0; w_done = 1; end
            cyc++;
        end
        if (!(aw_done && w_done)) begin
            S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0; timeout = 1;
            return;
        end
        while (!S_AXI_bvalid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!S_AXI_bvalid) begin timeout = 1; return; end
        resp = S_AXI_bresp;
        pulse_at_b = ctrl_wr_pulse;
        if (stall_b) return;
        S_AXI_bready = 1'b1;
        @(posedge clk); #1;
        S_AXI_bready = 1'b0;
        pulse_after = ctrl_wr_pulse;
    endtask

    // Status inputs are inverted while the response is held so a re-sample
    // would show up as a changing rdata.
    task automatic axi_read(input logic [31:0] addr, input int hold,
                            output logic [31:0] data, output logic [1:0] resp,
                            output bit stable, output int pulse_cycles,
                            output logic [7:0] pulse_first, output bit timeout);
        int cyc;
        bit hs;
        logic [255:0] saved;
        timeout = 0; stable = 1; pulse_cycles = 0; cyc = 0; hs = 0;
        data = 'x; resp = 'x; pulse_first = 'x;
        S_AXI_arvalid = 1'b1; S_AXI_araddr = addr; S_AXI_rready = 1'b0;
        while (!hs && cyc < 40) begin
            hs = S_AXI_arready;
            @(posedge clk); #1;
            cyc++;
        end
        S_AXI_arvalid = 1'b0;
        if (!hs || !S_AXI_rvalid) begin timeout = 1; return; end
        data = S_AXI_rdata; resp = S_AXI_rresp; pulse_first = stat_rd_pulse;
        if (stat_rd_pulse != 0) pulse_cycles++;
        saved = stat_regs;
        stat_regs = ~saved;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!S_AXI_rvalid || S_AXI_rdata !== data || S_AXI_rresp !== resp) stable = 0;
            if (stat_rd_pulse != 0) pulse_cycles++;
        end
        S_AXI_rready = 1'b1;
        @(posedge clk); #1;
        S_AXI_rready = 1'b0;
        if (stat_rd_pulse != 0) pulse_cycles++;
        stat_regs = saved;
    endtask

    logic [1:0]  g_resp;
    int          g_lat;
    logic [7:0]  g_pb, g_pa, g_pf;
    bit          g_to, g_stable;
    logic [31:0] g_data;
    int          g_pc;
    logic [1:0]  eb;
    rexp_t       er;

    task automatic test_reset();
        #12;
        vectors++;
        if ({S_AXI_awready, S_AXI_wready, S_AXI_arready, S_AXI_bvalid, S_AXI_rvalid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_hs: got %b want 00000", {S_AXI_awready, S_AXI_wready,
                     S_AXI_arready, S_AXI_bvalid, S_AXI_rvalid});
        end
        vectors++;
        if ({S_AXI_bresp, S_AXI_rresp, S_AXI_rdata, ctrl_wr_pulse, stat_rd_pulse} !== '0 ||
            ctrl_regs !== '0) begin
            miscompares++;
            $display("FAIL reset_data: rdata=%h ctrl=%h pulses=%h/%h want all 0",
                     S_AXI_rdata, ctrl_regs, ctrl_wr_pulse, stat_rd_pulse);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({S_AXI_awready, S_AXI_wready, S_AXI_arready} !== 3'b000) begin
            miscompares++;
            $display("FAIL ready_before_edge: got %b want 000",
                     {S_AXI_awready, S_AXI_wready, S_AXI_arready});
        end
        @(posedge clk); #1;
        vectors++;
        if ({S_AXI_awready, S_AXI_wready, S_AXI_arready} !== 3'b111) begin
            miscompares++;
            $display("FAIL ready_after_edge: got %b want 111",
                     {S_AXI_awready, S_AXI_wready, S_AXI_arready});
        end
    endtask

    task automatic test_same_edge();
        exp_b_q.push_back(OKAY);
        axi_write(32'h04, 32'hA5A5_1234, 4'hF, 0, 0, g_resp, g_lat, g_pb, g_pa, g_to);
        eb = exp_b_q.pop_front();
        vectors++;
        if (g_to || g_resp !== eb) begin
            miscompares++;
            $display("FAIL same_edge_bresp: got %b (timeout %0d) want %b", g_resp, g_to, eb);
        end
        vectors++;
        if (g_lat !== 1) begin
            miscompares++;
            $display("FAIL same_edge_latency: got %0d want 1", g_lat);
        end
        vectors++;
        if (g_pb !== 8'h02 || g_pa !== 8'h00) begin
            miscompares++;
            $display("FAIL same_edge_pulse: got %h then %h want 02 then 00", g_pb, g_pa);
        end
        vectors++;
        if (ctrl_regs[32 +: 32] !== 32'hA5A5_1234) begin
            miscompares++;
            $display("FAIL same_edge_reg1: got %h want a5a51234", ctrl_regs[32 +: 32]);
        end
    endtask

    task automatic test_order_strobe();
        axi_write(32'h00, 32'h1122_3344, 4'hF, 0, 0, g_resp, g_lat, g_pb, g_pa, g_to);
        exp_b_q.push_back(OKAY);
        axi_write(32'h00, 32'h0000_BB00, 4'h2, 2, 0, g_resp, g_lat, g_pb, g_pa, g_to);
        eb = exp_b_q.pop_front();
        vectors++;
        if (g_to || g_resp !== eb || ctrl_regs[31:0] !== 32'h1122_BB44) begin
            miscompares++;
            $display("FAIL w_first: resp %b reg0 %h want %b 1122bb44", g_resp, ctrl_regs[31:0], eb);
        end
        exp_b_q.push_back(OKAY);
        axi_write(32'h00, 32'h0077_0000, 4'h4, -2, 0, g_resp, g_lat, g_pb, g_pa, g_to);
        eb = exp_b_q.pop_front();
        vectors++;
        if (g_to || g_resp !== eb || ctrl_regs[31:0] !== 32'h1177_BB44) begin
            miscompares++;
            $display("FAIL aw_first: resp %b reg0 %h want %b 1177bb44", g_resp, ctrl_regs[31:0], eb);
        end
        exp_b_q.push_back(OKAY);
        axi_write(32'h00, 32'hFFFF_FFFF, 4'h0, 0, 0, g_resp, g_lat, g_pb, g_pa, g_to);
        eb = exp_b_q.pop_front();
        vectors++;
        if (g_to || g_resp !== eb || g_pb !== 8'h01 || ctrl_regs[31:0] !== 32'h1177_BB44) begin
            miscompares++;
            $display("FAIL strb_zero: resp %b pulse %h reg0 %h want %b 01 1177bb44",
                     g_resp, g_pb, ctrl_regs[31:0], eb);
        end
    endtask

    task automatic test_status_read();
        stat_regs[31:0]    = 32'hCAFE_F00D;
        stat_regs[255:224] = 32'h0BAD_BEEF;
        exp_r_q.push_back('{data: 32'hCAFE_F00D, resp: OKAY});
        axi_read(32'h20, 5, g_data, g_resp, g_stable, g_pc, g_pf, g_to);
        er = exp_r_q.pop_front();
        vectors++;
        if (g_to || g_data !== er.data || g_resp !== er.resp) begin
            miscompares++;
            $display("FAIL stat0_read: got %h/%b (timeout %0d) want %h/%b",
                     g_data, g_resp, g_to, er.data, er.resp);
        end
        vectors++;
        if (!g_stable) begin
            miscompares++;
            $display("FAIL stat0_hold: got unstable rdata/rresp want stable for 5 cycles");
        end
        vectors++;
        if (g_pc !== 1 || g_pf !== 8'h01) begin
            miscompares++;
            $display("FAIL stat0_pulse: got %0d cycles vec %h want 1 cycle vec 01", g_pc, g_pf);
        end
        exp_r_q.push_back('{data: 32'h0BAD_BEEF, resp: OKAY});
        axi_read(32'h3C, 0, g_data, g_resp, g_stable, g_pc, g_pf, g_to);
        er = exp_r_q.pop_front();
        vectors++;
        if (g_to || g_data !== er.data || g_resp !== er.resp || g_pf !== 8'h80 || g_pc !== 1) begin
            miscompares++;
            $display("FAIL stat7_read: got %h/%b pulse %h want %h/%b pulse 80",
                     g_data, g_resp, g_pf, er.data, er.resp);
        end
        vectors++;
        if (S_AXI_arready !== 1'b1 || S_AXI_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL read_b2b_ready: arready %b rvalid %b want 1 0", S_AXI_arready, S_AXI_rvalid);
        end
    endtask

    task automatic test_errors();
        logic [255:0] snap;
        snap = ctrl_regs;
        exp_b_q.push_back(SLVERR);
        axi_write(32'h20, 32'hDEAD_0001, 4'hF, 0, 0, g_resp, g_lat, g_pb, g_pa, g_to);
        eb = exp_b_q.pop_front();
        vectors++;
        if (g_to || g_resp !== eb || g_pb !== 8'h00 || ctrl_regs !== snap) begin
            miscompares++;
            $display("FAIL wr_status: resp %b pulse %h regs_changed %0d want %b 00 0",
                     g_resp, g_pb, ctrl_regs !== snap, eb);
        end
        exp_b_q.push_back(SLVERR);
        axi_write(32'h400, 32'hDEAD_0002, 4'hF, 0, 0, g_resp, g_lat, g_pb, g_pa, g_to);
        eb = exp_b_q.pop_front();
        vectors++;
        if (g_to || g_resp !== eb || g_pb !== 8'h00 || ctrl_regs !== snap) begin
            miscompares++;
            $display("FAIL wr_unmapped: resp %b pulse %h want %b 00", g_resp, g_pb, eb);
        end
        exp_r_q.push_back('{data: 32'h0, resp: SLVERR});
        axi_read(32'h400, 1, g_data, g_resp, g_stable, g_pc, g_pf, g_to);
        er = exp_r_q.pop_front();
        vectors++;
        if (g_to || g_data !== er.data || g_resp !== er.resp || g_pc !== 0) begin
            miscompares++;
            $display("FAIL rd_unmapped: got %h/%b pulses %0d want %h/%b 0",
                     g_data, g_resp, g_pc, er.data, er.resp);
        end
        exp_r_q.push_back('{data: 32'h0, resp: SLVERR});
        axi_read(32'h40, 0, g_data, g_resp, g_stable, g_pc, g_pf, g_to);
        er = exp_r_q.pop_front();
        vectors++;
        if (g_to || g_data !== er.data || g_resp !== er.resp) begin
            miscompares++;
            $display("FAIL rd_past_stat: got %h/%b want %h/%b", g_data, g_resp, er.data, er.resp);
        end
        exp_r_q.push_back('{data: 32'hA5A5_1234, resp: OKAY});
        axi_read(32'hFFFF_1005, 0, g_data, g_resp, g_stable, g_pc, g_pf, g_to);
        er = exp_r_q.pop_front();
        vectors++;
        if (g_to || g_data !== er.data || g_resp !== er.resp) begin
            miscompares++;
            $display("FAIL rd_alias: got %h/%b want %h/%b", g_data, g_resp, er.data, er.resp);
        end
    endtask

    task automatic test_simultaneous();
        axi_write(32'h0C, 32'h9, 4'hF, 0, 0, g_resp, g_lat, g_pb, g_pa, g_to);
        exp_b_q.push_back(OKAY);
        exp_r_q.push_back('{data: 32'h9, resp: OKAY});
        S_AXI_awvalid = 1'b1; S_AXI_awaddr = 32'h0C;
        S_AXI_wvalid = 1'b1; S_AXI_wdata = 32'h5; S_AXI_wstrb = 4'hF;
        @(posedge clk); #1;
        S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
        S_AXI_arvalid = 1'b1; S_AXI_araddr = 32'h0C;
        @(posedge clk); #1;
        S_AXI_arvalid = 1'b0;
        eb = exp_b_q.pop_front();
        er = exp_r_q.pop_front();
        vectors++;
        if (S_AXI_rvalid !== 1'b1 || S_AXI_rdata !== er.data || S_AXI_rresp !== er.resp) begin
            miscompares++;
            $display("FAIL sim_read_old: rvalid %b rdata %h/%b want 1 %h/%b",
                     S_AXI_rvalid, S_AXI_rdata, S_AXI_rresp, er.data, er.resp);
        end
        vectors++;
        if (S_AXI_bvalid !== 1'b1 || S_AXI_bresp !== eb || ctrl_regs[96 +: 32] !== 32'h5) begin
            miscompares++;
            $display("FAIL sim_write: bvalid %b bresp %b reg3 %h want 1 %b 00000005",
                     S_AXI_bvalid, S_AXI_bresp, ctrl_regs[96 +: 32], eb);
        end
        S_AXI_bready = 1'b1; S_AXI_rready = 1'b1;
        @(posedge clk); #1;
        S_AXI_bready = 1'b0; S_AXI_rready = 1'b0;
        vectors++;
        if ({S_AXI_bvalid, S_AXI_rvalid, S_AXI_awready, S_AXI_wready, S_AXI_arready} !== 5'b00111) begin
            miscompares++;
            $display("FAIL sim_release: got %b want 00111", {S_AXI_bvalid, S_AXI_rvalid,
                     S_AXI_awready, S_AXI_wready, S_AXI_arready});
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            exp_b_q.push_back(OKAY);
            axi_write(32'h10 + 32'(4*k), 32'h100 + 32'(k), 4'hF, 0, 0, g_resp, g_lat, g_pb, g_pa, g_to);
            eb = exp_b_q.pop_front();
            vectors++;
            if (g_to || g_resp !== eb || S_AXI_awready !== 1'b1 || S_AXI_wready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_write%0d: resp %b awready %b wready %b want %b 1 1",
                         k, g_resp, S_AXI_awready, S_AXI_wready, eb);
            end
        end
        vectors++;
        if (ctrl_regs[128 +: 96] !== {32'h102, 32'h101, 32'h100}) begin
            miscompares++;
            $display("FAIL b2b_regs: got %h want 000001020000010100000100", ctrl_regs[128 +: 96]);
        end
    endtask

    task automatic test_reset_mid();
        axi_write(32'h08, 32'hDEAD_BEEF, 4'hF, 0, 1, g_resp, g_lat, g_pb, g_pa, g_to);
        vectors++;
        if (g_to || S_AXI_bvalid !== 1'b1 || g_resp !== OKAY) begin
            miscompares++;
            $display("FAIL stall_bvalid: bvalid %b resp %b want 1 00", S_AXI_bvalid, g_resp);
        end
        @(posedge clk); #1;
        vectors++;
        if (S_AXI_bvalid !== 1'b1 || S_AXI_awready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold: bvalid %b awready %b want 1 0", S_AXI_bvalid, S_AXI_awready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (S_AXI_bvalid !== 1'b0 || ctrl_regs !== '0 ||
            {S_AXI_awready, S_AXI_wready, S_AXI_arready} !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset: bvalid %b ctrl %h readys %b want 0 0 000", S_AXI_bvalid,
                     ctrl_regs, {S_AXI_awready, S_AXI_wready, S_AXI_arready});
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({S_AXI_awready, S_AXI_wready, S_AXI_arready, S_AXI_bvalid} !== 4'b1110) begin
            miscompares++;
            $display("FAIL post_reset_ready: got %b want 1110",
                     {S_AXI_awready, S_AXI_wready, S_AXI_arready, S_AXI_bvalid});
        end
        exp_b_q.push_back(OKAY);
        axi_write(32'h08, 32'h1357_9BDF, 4'hF, 1, 0, g_resp, g_lat, g_pb, g_pa, g_to);
        eb = exp_b_q.pop_front();
        vectors++;
        if (g_to || g_resp !== eb || g_pb !== 8'h04 || ctrl_regs[64 +: 32] !== 32'h1357_9BDF) begin
            miscompares++;
            $display("FAIL fresh_write: resp %b pulse %h reg2 %h want %b 04 13579bdf",
                     g_resp, g_pb, ctrl_regs[64 +: 32], eb);
        end
        exp_r_q.push_back('{data: 32'h1357_9BDF, resp: OKAY});
        axi_read(32'h08, 2, g_data, g_resp, g_stable, g_pc, g_pf, g_to);
        er = exp_r_q.pop_front();
        vectors++;
        if (g_to || g_data !== er.data || g_resp !== er.resp || g_pc !== 0) begin
            miscompares++;
            $display("FAIL fresh_read: got %h/%b pulses %0d want %h/%b 0",
                     g_data, g_resp, g_pc, er.data, er.resp);
        end
    endtask

    initial begin
        test_reset();
        test_same_edge();
        test_order_strobe();
        test_status_read();
        test_errors();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
